// File: rtl/fp16_mult_sched.sv
// fp16_mult_sched: round-robin arbiter sharing one multi-cycle FP16 multiplier among NUM_REQ requesters.
// Latency: accept at N, mul_start at N+1, response the cycle after mul_done (or after the watchdog fires).
// Backpressure: one operation in flight; req_ready stays low until the response handshake completes.
// Ports:
//   clk/rst                   clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake; req_a/req_b packed 16 bits per requester
//   rsp_valid/rsp_ready       result handshake; rsp_id, rsp_product, rsp_timeout held until accepted
//   mul_start/mul_a/mul_b     start pulse and held operands to the multiplier
//   mul_done/mul_product      multiplier completion, sampled only while waiting
module fp16_mult_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_product,
  output logic                    rsp_timeout,
  output logic                    mul_start,
  output logic [15:0]             mul_a,
  output logic [15:0]             mul_b,
  input  logic                    mul_done,
  input  logic [15:0]             mul_product
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [ID_W:0]  NUM_W     = (ID_W+1)'(NUM_REQ);
  localparam logic [7:0]     TIMEOUT_W = 8'(TIMEOUT);
  localparam logic [15:0]    QNAN      = 16'h7E00;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      timer_q, timer_d;
  logic [15:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_product_q, rsp_product_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_vld;
  logic [ID_W:0]        grant_off, grant_sum, ptr_inc;
  logic [ID_W-1:0]      grant_id, ptr_next;
  logic [15:0]          sel_a, sel_b;

  assign valid_dbl = {req_valid, req_valid} >> rr_ptr_q;
  assign valid_rot = valid_dbl[NUM_REQ-1:0];

  always_comb begin
    grant_vld = 1'b0;
    grant_off = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_vld = 1'b1;
        grant_off = (ID_W+1)'(k);
      end
    end
  end

  // Undo the rotation: winner = (rr_ptr + offset) mod NUM_REQ.
  assign grant_sum = {1'b0, rr_ptr_q} + grant_off;
  assign grant_id  = (grant_sum >= NUM_W) ? ID_W'(grant_sum - NUM_W) : ID_W'(grant_sum);
  assign ptr_inc   = {1'b0, grant_id} + (ID_W+1)'(1);
  assign ptr_next  = (ptr_inc == NUM_W) ? '0 : ptr_inc[ID_W-1:0];

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        sel_a        = req_a[16*k +: 16];
        sel_b        = req_b[16*k +: 16];
        req_ready[k] = (state_q == S_IDLE) && grant_vld;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          mul_a_d  = sel_a;
          mul_b_d  = sel_b;
          rsp_id_d = grant_id;
          rr_ptr_d = ptr_next;
          state_d  = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle still delivers the real product.
        if (mul_done) begin
          rsp_product_d = mul_product;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (timer_q == TIMEOUT_W) begin
          rsp_product_d = QNAN;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign mul_start   = (state_q == S_START);
  assign rsp_valid   = (state_q == S_RESP);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
